// File: rtl/mipi_csi2_byte_tx_if.sv
// mipi_csi2_byte_tx_if
// Packet-request, payload-stream and lane-byte signals of the CSI-2 byte-clock
// transmitter. The slave modport is the transmitter. The master modport is the
// packet source / PHY side.
interface mipi_csi2_byte_tx_if;
  logic        I_Pkt_Req;
  logic [5:0]  I_Pkt_DT;
  logic [15:0] I_Pkt_WC;
  logic        O_Pkt_Ack;
  logic [15:0] I_Payload_Data;
  logic        I_Payload_Valid;
  logic        O_Payload_Ready;
  logic        O_HS_Req;
  logic        O_Lane_Valid;
  logic [7:0]  O_Lane0_Data;
  logic [7:0]  O_Lane1_Data;
  logic        O_Busy;
  logic        O_Underrun;

  modport master (
    output I_Pkt_Req, I_Pkt_DT, I_Pkt_WC, I_Payload_Data, I_Payload_Valid,
    input  O_Pkt_Ack, O_Payload_Ready, O_HS_Req, O_Lane_Valid,
           O_Lane0_Data, O_Lane1_Data, O_Busy, O_Underrun
  );

  modport slave (
    input  I_Pkt_Req, I_Pkt_DT, I_Pkt_WC, I_Payload_Data, I_Payload_Valid,
    output O_Pkt_Ack, O_Payload_Ready, O_HS_Req, O_Lane_Valid,
           O_Lane0_Data, O_Lane1_Data, O_Busy, O_Underrun
  );
endinterface

// File: rtl/mipi_csi2_byte_tx.sv
// mipi_csi2_byte_tx
// CSI-2 packet transmitter on the byte-clock side of a 2-lane D-PHY TX.
// It emits one HS burst per packet request as per-lane bytes:
// HS-zero, sync (B8), header+ECC, payload, CRC-16, HS-trail, then one LP gap cycle.
// The burst always has its full length. A missing payload beat is sent as
// zero bytes and raises O_Underrun.
// Optional feature: define MIPI_TX_CRC_EN to compute the payload CRC-16.
// Without it, the CRC bytes are sent as 00,00 and the timing is unchanged.
module mipi_csi2_byte_tx #(
  parameter int         MIPI_LANE_NUM   = 2,
  parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0,
  parameter int         HS_PREP_CYCLES  = 4,
  parameter int         HS_TRAIL_CYCLES = 4
) (
  input  logic               I_Mipi_CSI_Byte_CLK,
  input  logic               Rst_n,
  mipi_csi2_byte_tx_if.slave io_csi
);

  if (MIPI_LANE_NUM != 2 || HS_PREP_CYCLES < 1 || HS_TRAIL_CYCLES < 1) begin : g_param_check
    $error("mipi_csi2_byte_tx: needs MIPI_LANE_NUM=2 and HS prep/trail cycles >= 1");
  end

  localparam logic [7:0] PREP_LOAD  = 8'(HS_PREP_CYCLES - 1);
  localparam logic [7:0] TRAIL_LOAD = 8'(HS_TRAIL_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PREP, S_SYNC, S_HDR0, S_HDR1, S_PAYLOAD, S_CRC, S_TRAIL, S_LPGAP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_dt;
  logic [15:0] r_wc;
  logic        r_short;
  logic [7:0]  r_cnt8;
  logic [15:0] r_beat_cnt;
  logic [7:0]  r_lane0, r_lane1;
  logic [7:0]  r_fill0, r_fill1;
  logic        r_hs, r_ack;
  logic [7:0]  w_lane0_nxt, w_lane1_nxt;
  logic        w_hs_nxt;
  logic        w_req_take;
  logic [7:0]  w_di;
  logic [5:0]  w_ecc;
  logic [15:0] w_crc;

  // 6-bit Hamming ECC over the 24 header bits, D0 = DI[0].
  function automatic logic [5:0] f_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  assign w_di       = {VIRTUAL_CHANNEL, r_dt};
  assign w_ecc      = f_ecc({r_wc, w_di});
  assign w_req_take = (r_state == S_IDLE) && io_csi.I_Pkt_Req;

`ifdef MIPI_TX_CRC_EN
  logic [15:0] r_crc;

  // Reflected CRC-16 (poly 0x8408), one byte LSB-first.
  function automatic logic [15:0] f_crc_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  // Seed during the header, then fold the lane0 byte and then the lane1 byte of every beat.
  always_ff @(posedge I_Mipi_CSI_Byte_CLK or negedge Rst_n) begin
    if (!Rst_n)                       r_crc <= 16'hFFFF;
    else if (r_state == S_HDR0)       r_crc <= 16'hFFFF;
    else if (r_state == S_PAYLOAD)    r_crc <= f_crc_byte(f_crc_byte(r_crc, w_lane0_nxt), w_lane1_nxt);
  end

  assign w_crc = r_crc;
`else
  assign w_crc = 16'h0000;
`endif

  // State register.
  always_ff @(posedge I_Mipi_CSI_Byte_CLK or negedge Rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and the lane bytes for the current state.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case infers a latch.
    w_state_nxt = r_state;
    w_lane0_nxt = 8'h00;
    w_lane1_nxt = 8'h00;
    w_hs_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: if (io_csi.I_Pkt_Req) w_state_nxt = S_PREP;
      S_PREP: begin
        w_hs_nxt = 1'b1;
        if (r_cnt8 == 8'd0) w_state_nxt = S_SYNC;
      end
      S_SYNC: begin
        w_hs_nxt    = 1'b1;
        w_lane0_nxt = 8'hB8;
        w_lane1_nxt = 8'hB8;
        w_state_nxt = S_HDR0;
      end
      S_HDR0: begin
        w_hs_nxt    = 1'b1;
        w_lane0_nxt = w_di;
        w_lane1_nxt = r_wc[7:0];
        w_state_nxt = S_HDR1;
      end
      S_HDR1: begin
        w_hs_nxt    = 1'b1;
        w_lane0_nxt = r_wc[15:8];
        w_lane1_nxt = {2'b00, w_ecc};
        if (r_short)              w_state_nxt = S_TRAIL;
        else if (r_wc == 16'd0)   w_state_nxt = S_CRC;
        else                      w_state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        w_hs_nxt = 1'b1;
        if (io_csi.I_Payload_Valid) begin
          w_lane0_nxt = io_csi.I_Payload_Data[7:0];
          w_lane1_nxt = io_csi.I_Payload_Data[15:8];
        end
        if (r_beat_cnt == 16'd0) w_state_nxt = S_CRC;
      end
      S_CRC: begin
        w_hs_nxt    = 1'b1;
        w_lane0_nxt = w_crc[7:0];
        w_lane1_nxt = w_crc[15:8];
        w_state_nxt = S_TRAIL;
      end
      S_TRAIL: begin
        w_hs_nxt    = 1'b1;
        w_lane0_nxt = r_fill0;
        w_lane1_nxt = r_fill1;
        if (r_cnt8 == 8'd0) w_state_nxt = S_LPGAP;
      end
      S_LPGAP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the packet request. Long packets carry an even byte count.
  always_ff @(posedge I_Mipi_CSI_Byte_CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      r_dt    <= 6'd0;
      r_wc    <= 16'd0;
      r_short <= 1'b0;
    end else if (w_req_take) begin
      r_dt    <= io_csi.I_Pkt_DT;
      r_short <= (io_csi.I_Pkt_DT < 6'h10);
      r_wc    <= (io_csi.I_Pkt_DT < 6'h10) ? io_csi.I_Pkt_WC : {io_csi.I_Pkt_WC[15:1], 1'b0};
    end
  end

  // Prep/trail length counter and payload beat counter. Both count down to zero.
  always_ff @(posedge I_Mipi_CSI_Byte_CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt8     <= 8'd0;
      r_beat_cnt <= 16'd0;
    end else begin
      if (w_req_take)
        r_cnt8 <= PREP_LOAD;
      else if (r_state != S_TRAIL && w_state_nxt == S_TRAIL)
        r_cnt8 <= TRAIL_LOAD;
      else if ((r_state == S_PREP || r_state == S_TRAIL) && r_cnt8 != 8'd0)
        r_cnt8 <= r_cnt8 - 8'd1;

      if (r_state == S_HDR1)
        r_beat_cnt <= {1'b0, r_wc[15:1]} - 16'd1;
      else if (r_state == S_PAYLOAD && r_beat_cnt != 16'd0)
        r_beat_cnt <= r_beat_cnt - 16'd1;
    end
  end

  // Registered lane outputs, plus the trail fill taken from the last byte sent on each lane.
  always_ff @(posedge I_Mipi_CSI_Byte_CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      r_lane0 <= 8'h00;
      r_lane1 <= 8'h00;
      r_hs    <= 1'b0;
      r_ack   <= 1'b0;
      r_fill0 <= 8'h00;
      r_fill1 <= 8'h00;
    end else begin
      r_lane0 <= w_lane0_nxt;
      r_lane1 <= w_lane1_nxt;
      r_hs    <= w_hs_nxt;
      r_ack   <= w_req_take;
      if (r_state == S_HDR1 || r_state == S_CRC) begin
        r_fill0 <= {8{~w_lane0_nxt[7]}};
        r_fill1 <= {8{~w_lane1_nxt[7]}};
      end
    end
  end

  assign io_csi.O_Pkt_Ack       = r_ack;
  assign io_csi.O_Payload_Ready = (r_state == S_PAYLOAD);
  assign io_csi.O_Underrun      = (r_state == S_PAYLOAD) && !io_csi.I_Payload_Valid;
  assign io_csi.O_HS_Req        = r_hs;
  assign io_csi.O_Lane_Valid    = r_hs;
  assign io_csi.O_Lane0_Data    = r_lane0;
  assign io_csi.O_Lane1_Data    = r_lane1;
  assign io_csi.O_Busy          = (r_state != S_IDLE);

endmodule
